// File: rtl/nvdla_cdma_param_fifo_if.sv
// nvdla_cdma_param_fifo_if
//   Handshake bundle between a CDMA producer, the parameter FIFO and its
//   consumer.
//
//   Valid/ready contract (both sides): a transfer happens on a rising clk
//   edge where valid (wr_req / rd_req) and ready (wr_ready / rd_ready) are
//   both 1. Data travels with valid. A source holds valid and data steady
//   until the transfer. A sink may change ready at any time.
//
//   Signals:
//     wr_req   producer -> fifo  write valid
//     wr_ready fifo -> producer  write ready (registered)
//     wr_data  producer -> fifo  write data
//     rd_req   fifo -> consumer  read valid
//     rd_ready consumer -> fifo  read accept
//     rd_data  fifo -> consumer  read data, meaningful while rd_req=1
//   Modports:
//     slave  : the FIFO's own view
//     master : the view of the producer/consumer pair driving the FIFO
interface nvdla_cdma_param_fifo_if #(
   parameter int WIDTH = 11
);
   logic             wr_req;
   logic             wr_ready;
   logic [WIDTH-1:0] wr_data;
   logic             rd_req;
   logic             rd_ready;
   logic [WIDTH-1:0] rd_data;

   modport slave  (input  wr_req, wr_data, rd_ready,
                   output wr_ready, rd_req, rd_data);
   modport master (output wr_req, wr_data, rd_ready,
                   input  wr_ready, rd_req, rd_data);
endinterface

// File: rtl/nvdla_cdma_param_fifo.sv
// nvdla_cdma_param_fifo
//   Single-clock show-ahead FIFO for CDMA datapaths. It has these features:
//     - a runtime occupancy cap
//     - a synchronous flush
//     - live occupancy and high-water-mark outputs
//     - an idle flag that can drive a clock-gate enable (enable = !idle)
//   Ports:
//     clk       core clock
//     reset_    asynchronous active-low reset
//     bus       write/read handshake bundle (slave view)
//     flush     synchronous clear; it overrides any push or pop in that cycle
//     wr_limit  occupancy cap. A value of 0 or above DEPTH means DEPTH.
//     wr_count  current occupancy (registered)
//     hwm       highest occupancy seen since reset or flush
//     idle      no handshake activity is possible next cycle
module nvdla_cdma_param_fifo #(
   parameter  int WIDTH = 11,
   parameter  int DEPTH = 128,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic                clk,
   input  logic                reset_,
   nvdla_cdma_param_fifo_if.slave bus,
   input  logic                flush,
   input  logic [CW-1:0]       wr_limit,
   output logic [CW-1:0]       wr_count,
   output logic [CW-1:0]       hwm,
   output logic                idle
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_adr;
   logic [AW-1:0]    rd_adr;
   logic [CW-1:0]    count;
   logic [CW-1:0]    count_next;
   logic [CW-1:0]    hwm_q;
   logic [CW-1:0]    eff_limit;
   logic             wr_ready_q;
   logic             rd_valid;
   logic             push;
   logic             pop;

   always_comb begin
      eff_limit = wr_limit;
      if (wr_limit == '0 || wr_limit > CW'(DEPTH)) eff_limit = CW'(DEPTH);
   end

   assign rd_valid   = (count != '0);
   assign push       = bus.wr_req & wr_ready_q;
   assign pop        = rd_valid & bus.rd_ready;
   assign count_next = count + CW'(push) - CW'(pop);

   // The ready flag is registered. As a result, a new wr_limit value only
   // affects wr_ready one cycle later. Lowering the cap below the current
   // occupancy blocks further writes. It never drops data.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         wr_adr     <= '0;
         rd_adr     <= '0;
         count      <= '0;
         hwm_q      <= '0;
         wr_ready_q <= 1'b1;
      end else if (flush) begin
         wr_adr     <= '0;
         rd_adr     <= '0;
         count      <= '0;
         hwm_q      <= '0;
         wr_ready_q <= 1'b1;
      end else begin
         if (push) wr_adr <= wr_adr + AW'(1);
         if (pop)  rd_adr <= rd_adr + AW'(1);
         count      <= count_next;
         wr_ready_q <= (count_next < eff_limit);
         if (count_next > hwm_q) hwm_q <= count_next;
      end
   end

   // The storage array has no reset. Its contents are only observable
   // through rd_adr while count is non-zero.
   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_adr] <= bus.wr_data;
   end

   assign bus.wr_ready = wr_ready_q;
   assign bus.rd_req   = rd_valid;
   assign bus.rd_data  = mem[rd_adr];
   assign wr_count     = count;
   assign hwm          = hwm_q;

   // The last term catches a pending wr_ready update, for example after
   // wr_limit has changed. In that case the clock must keep running.
   assign idle = !bus.wr_req && !pop && !flush && (wr_ready_q == (count < eff_limit));
endmodule

// File: tb/tb_nvdla_cdma_param_fifo.sv
// Bench for nvdla_cdma_param_fifo.
// It uses two instances:
//   dut_a : 11 bits x 128 entries, exercised with directed vectors
//   dut_b : 32 bits x 16 entries, exercised with random traffic
// The drivers change inputs 1ns after the rising edge. A negedge monitor
// per instance keeps a reference model and an expected-data queue, and it
// compares every output once per cycle.
module tb_nvdla_cdma_param_fifo;
   logic clk;
   logic reset_;
   int   total;
   int   bad;

   nvdla_cdma_param_fifo_if #(.WIDTH(11)) a_if ();
   logic       a_flush;
   logic [7:0] a_wr_limit;
   logic [7:0] a_wr_count;
   logic [7:0] a_hwm;
   logic       a_idle;

   nvdla_cdma_param_fifo_if #(.WIDTH(32)) b_if ();
   logic       b_flush;
   logic [4:0] b_wr_limit;
   logic [4:0] b_wr_count;
   logic [4:0] b_hwm;
   logic       b_idle;

   nvdla_cdma_param_fifo #(.WIDTH(11), .DEPTH(128)) dut_a (
      .clk(clk), .reset_(reset_), .bus(a_if), .flush(a_flush),
      .wr_limit(a_wr_limit), .wr_count(a_wr_count), .hwm(a_hwm), .idle(a_idle));

   nvdla_cdma_param_fifo #(.WIDTH(32), .DEPTH(16)) dut_b (
      .clk(clk), .reset_(reset_), .bus(b_if), .flush(b_flush),
      .wr_limit(b_wr_limit), .wr_count(b_wr_count), .hwm(b_hwm), .idle(b_idle));

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required finish earlier");
      $fatal(1, "watchdog");
   end

   // ---------------- checking helpers ----------------
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- scoreboard / model for dut_a ----------------
   logic [10:0] exp_qa[$];
   int   ma_cnt, ma_hwm, ma_lim;
   logic ma_rdy;

   task automatic mon_a();
      logic m_push, m_pop;
      if (!reset_) begin
         chk("a_rst_wr_ready", a_if.wr_ready, 1);
         chk("a_rst_rd_req", a_if.rd_req, 0);
         chk("a_rst_wr_count", a_wr_count, 0);
         chk("a_rst_hwm", a_hwm, 0);
         ma_cnt = 0; ma_hwm = 0; ma_rdy = 1'b1;
         exp_qa.delete();
      end else begin
         ma_lim = (a_wr_limit == 0 || a_wr_limit > 128) ? 128 : int'(a_wr_limit);
         m_pop  = (ma_cnt != 0) && a_if.rd_ready;
         m_push = a_if.wr_req && ma_rdy;
         chk("a_wr_ready", a_if.wr_ready, ma_rdy);
         chk("a_rd_req", a_if.rd_req, ma_cnt != 0);
         chk("a_wr_count", a_wr_count, ma_cnt);
         chk("a_hwm", a_hwm, ma_hwm);
         chk("a_idle", a_idle, !a_if.wr_req && !m_pop && !a_flush && (ma_rdy == (ma_cnt < ma_lim)));
         if (ma_cnt != 0) begin
            if (exp_qa.size() == 0) begin
               total++; bad++;
               $display("FAIL a_queue: got empty expected queue, required an entry");
            end else chk("a_rd_data", a_if.rd_data, exp_qa[0]);
         end
         if (a_flush) begin
            exp_qa.delete();
            ma_cnt = 0; ma_hwm = 0; ma_rdy = 1'b1;
         end else begin
            if (m_pop && exp_qa.size() != 0) void'(exp_qa.pop_front());
            if (m_push) exp_qa.push_back(a_if.wr_data);
            ma_cnt = ma_cnt + int'(m_push) - int'(m_pop);
            ma_rdy = (ma_cnt < ma_lim);
            if (ma_cnt > ma_hwm) ma_hwm = ma_cnt;
         end
      end
   endtask

   // ---------------- scoreboard / model for dut_b ----------------
   logic [31:0] exp_qb[$];
   int   mb_cnt, mb_hwm, mb_lim;
   logic mb_rdy;

   task automatic mon_b();
      logic m_push, m_pop;
      if (!reset_) begin
         chk("b_rst_wr_ready", b_if.wr_ready, 1);
         chk("b_rst_rd_req", b_if.rd_req, 0);
         chk("b_rst_wr_count", b_wr_count, 0);
         chk("b_rst_hwm", b_hwm, 0);
         mb_cnt = 0; mb_hwm = 0; mb_rdy = 1'b1;
         exp_qb.delete();
      end else begin
         mb_lim = (b_wr_limit == 0 || b_wr_limit > 16) ? 16 : int'(b_wr_limit);
         m_pop  = (mb_cnt != 0) && b_if.rd_ready;
         m_push = b_if.wr_req && mb_rdy;
         chk("b_wr_ready", b_if.wr_ready, mb_rdy);
         chk("b_rd_req", b_if.rd_req, mb_cnt != 0);
         chk("b_wr_count", b_wr_count, mb_cnt);
         chk("b_hwm", b_hwm, mb_hwm);
         chk("b_idle", b_idle, !b_if.wr_req && !m_pop && !b_flush && (mb_rdy == (mb_cnt < mb_lim)));
         if (mb_cnt != 0) begin
            if (exp_qb.size() == 0) begin
               total++; bad++;
               $display("FAIL b_queue: got empty expected queue, required an entry");
            end else chk("b_rd_data", b_if.rd_data, exp_qb[0]);
         end
         if (b_flush) begin
            exp_qb.delete();
            mb_cnt = 0; mb_hwm = 0; mb_rdy = 1'b1;
         end else begin
            if (m_pop && exp_qb.size() != 0) void'(exp_qb.pop_front());
            if (m_push) exp_qb.push_back(b_if.wr_data);
            mb_cnt = mb_cnt + int'(m_push) - int'(m_pop);
            mb_rdy = (mb_cnt < mb_lim);
            if (mb_cnt > mb_hwm) mb_hwm = mb_cnt;
         end
      end
   endtask

   always @(negedge clk) begin
      mon_a();
      mon_b();
   end

   // ---------------- stimulus ----------------
   initial begin
      total = 0; bad = 0;
      reset_ = 1'b0;
      a_if.wr_req = 1'b0; a_if.wr_data = '0; a_if.rd_ready = 1'b0;
      a_flush = 1'b0; a_wr_limit = '0;
      b_if.wr_req = 1'b0; b_if.wr_data = '0; b_if.rd_ready = 1'b0;
      b_flush = 1'b0; b_wr_limit = '0;
      repeat (3) step();
      reset_ = 1'b1;
      chk("reset_wr_ready", a_if.wr_ready, 1);
      chk("reset_rd_req", a_if.rd_req, 0);
      chk("reset_wr_count", a_wr_count, 0);
      chk("reset_hwm", a_hwm, 0);
      chk("reset_idle", a_idle, 1);

      // 128 pushes into a full-depth FIFO, then drain in order
      for (int i = 0; i < 128; i++) begin
         a_if.wr_req = 1'b1; a_if.wr_data = 11'(i);
         chk("fill_ready", a_if.wr_ready, 1);
         step();
      end
      a_if.wr_req = 1'b0;
      chk("full_ready", a_if.wr_ready, 0);
      chk("full_count", a_wr_count, 128);
      chk("full_hwm", a_hwm, 128);
      a_if.rd_ready = 1'b1;
      for (int i = 0; i < 128; i++) begin
         chk("drain_data", a_if.rd_data, 11'(i));
         step();
      end
      a_if.rd_ready = 1'b0;
      chk("drain_rd_req", a_if.rd_req, 0);
      chk("drain_count", a_wr_count, 0);
      chk("drain_hwm", a_hwm, 128);

      // write limit of 5 under continuous wr_req
      a_wr_limit = 8'd5;
      a_if.wr_req = 1'b1;
      for (int i = 0; i < 8; i++) begin
         a_if.wr_data = 11'(100 + i);
         step();
      end
      chk("lim_count", a_wr_count, 5);
      chk("lim_ready", a_if.wr_ready, 0);
      a_if.wr_data = 11'd200;
      a_if.rd_ready = 1'b1;
      chk("lim_pop_data", a_if.rd_data, 100);
      step();
      a_if.rd_ready = 1'b0;
      chk("lim_reopen_ready", a_if.wr_ready, 1);
      chk("lim_reopen_count", a_wr_count, 4);
      step();
      a_if.wr_req = 1'b0;
      chk("lim_sixth_count", a_wr_count, 5);
      chk("lim_sixth_ready", a_if.wr_ready, 0);

      // one pop to count 4, then 300 cycles of simultaneous push/pop
      a_if.rd_ready = 1'b1;
      step();
      chk("stream_start_count", a_wr_count, 4);
      a_if.wr_req = 1'b1;
      for (int i = 0; i < 300; i++) begin
         a_if.wr_data = 11'(300 + i);
         chk("stream_ready", a_if.wr_ready, 1);
         chk("stream_count", a_wr_count, 4);
         step();
      end
      a_if.wr_req = 1'b0;
      chk("stream_tail_data", a_if.rd_data, 596);

      // drain, refill to 37, then flush with traffic in the same cycle
      a_wr_limit = 8'd0;
      repeat (4) step();
      a_if.rd_ready = 1'b0;
      chk("preflush_empty", a_if.rd_req, 0);
      a_if.wr_req = 1'b1;
      for (int i = 0; i < 37; i++) begin
         a_if.wr_data = 11'(400 + i);
         step();
      end
      chk("preflush_count", a_wr_count, 37);
      chk("preflush_hwm", a_hwm, 128);
      a_flush = 1'b1; a_if.wr_data = 11'h7FF; a_if.rd_ready = 1'b1;
      step();
      a_flush = 1'b0; a_if.wr_req = 1'b0; a_if.rd_ready = 1'b0;
      chk("flush_count", a_wr_count, 0);
      chk("flush_hwm", a_hwm, 0);
      chk("flush_rd_req", a_if.rd_req, 0);
      chk("flush_ready", a_if.wr_ready, 1);
      a_if.wr_req = 1'b1; a_if.wr_data = 11'h123;
      step();
      a_if.wr_req = 1'b0;
      chk("postflush_data", a_if.rd_data, 11'h123);
      chk("postflush_hwm", a_hwm, 1);
      a_if.rd_ready = 1'b1;
      step();
      a_if.rd_ready = 1'b0;

      // asynchronous reset in the middle of a burst
      a_if.wr_req = 1'b1;
      for (int i = 0; i < 20; i++) begin
         a_if.wr_data = 11'(500 + i);
         step();
      end
      chk("burst_count", a_wr_count, 20);
      a_if.wr_req = 1'b0;
      reset_ = 1'b0;
      #1;
      chk("async_rst_count", a_wr_count, 0);
      chk("async_rst_rd_req", a_if.rd_req, 0);
      chk("async_rst_hwm", a_hwm, 0);
      chk("async_rst_ready", a_if.wr_ready, 1);
      chk("async_rst_idle", a_idle, 1);
      step();
      reset_ = 1'b1;
      a_if.wr_req = 1'b1; a_if.wr_data = 11'h5A5;
      step();
      a_if.wr_req = 1'b0;
      chk("rst_push_rd_req", a_if.rd_req, 1);
      chk("rst_push_data", a_if.rd_data, 11'h5A5);
      chk("rst_push_count", a_wr_count, 1);
      a_if.rd_ready = 1'b1;
      step();
      a_if.rd_ready = 1'b0;

      // random traffic on the 32x16 instance
      for (int i = 0; i < 3000; i++) begin
         if (i % 600 == 0) b_wr_limit = 5'($urandom_range(0, 20));
         b_if.wr_req   = 1'($urandom_range(0, 1));
         b_if.rd_ready = ($urandom_range(0, 9) < 3);
         b_if.wr_data  = $urandom;
         b_flush       = ($urandom_range(0, 199) == 0);
         step();
      end
      b_if.wr_req = 1'b0; b_if.rd_ready = 1'b0; b_flush = 1'b0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
